// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue path: opcode/funct5 encodings, the
// default bubble word, the issue-action encoding and the source-usage
// decode helper (also reusable by the decode stage).
package fpu_pkg;

    // opcode[6:2] groups: 100xx is the fused multiply-add family.
    localparam logic [2:0] OPC_FP_R4_HI = 3'b100;
    localparam logic [4:0] OPC_OP_FP    = 5'b10100;

    // funct5 values (instr[31:27]) inside OP-FP.
    localparam logic [4:0] F5_FADD    = 5'b00000;
    localparam logic [4:0] F5_FSUB    = 5'b00001;
    localparam logic [4:0] F5_FMUL    = 5'b00010;
    localparam logic [4:0] F5_FDIV    = 5'b00011;
    localparam logic [4:0] F5_FSGNJ   = 5'b00100;
    localparam logic [4:0] F5_FMINMAX = 5'b00101;
    localparam logic [4:0] F5_FCMP    = 5'b10100;
    localparam logic [4:0] F5_FSQRT   = 5'b01011;
    localparam logic [4:0] F5_FCLASS  = 5'b11100;

    localparam logic [31:0] BUBBLE = '0;

    typedef struct packed {
        logic legal;
        logic use_rs2;
        logic use_rs3;
    } src_use_t;

    // What the issue stage does with the FIFO head on the coming edge.
    typedef enum logic [2:0] {
        ACT_FLUSH,
        ACT_IDLE,
        ACT_ILLEGAL,
        ACT_STALL,
        ACT_ISSUE
    } issue_act_e;

    // rs1 is read by every legal op, so only rs2/rs3 usage is reported.
    function automatic src_use_t fp_src_use(input logic [31:0] instr);
        logic [4:0] opc;
        logic [4:0] f5;
        src_use_t   u;
        opc = instr[6:2];
        f5  = instr[31:27];
        u   = '0;
        if (opc[4:2] == OPC_FP_R4_HI) begin
            u = '{legal: 1'b1, use_rs2: 1'b1, use_rs3: 1'b1};
        end else if (opc == OPC_OP_FP) begin
            case (f5)
                F5_FADD, F5_FSUB, F5_FMUL, F5_FDIV,
                F5_FSGNJ, F5_FMINMAX, F5_FCMP:
                    u = '{legal: 1'b1, use_rs2: 1'b1, use_rs3: 1'b0};
                F5_FSQRT:
                    u.legal = 1'b1;
                // funct5 11100 with funct3[0]=0 is FMV.X.W, not FCLASS.
                F5_FCLASS:
                    u.legal = instr[12];
                default: ;
            endcase
        end
        return u;
    endfunction

endpackage

// File: rtl/fpu_issue_if.sv
// Handshake/bus bundle between upstream, the issue stage and the FPU.
//   in_valid/in_instr/in_ready : upstream push handshake
//   flush                      : drop all queued instructions
//   fpu_instr/fpu_valid        : registered issue to the FPU
//   illegal/hazard_stall       : registered status pulses
interface fpu_issue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic [31:0] fpu_instr;
    logic        fpu_valid;
    logic        illegal;
    logic        hazard_stall;

    modport master (
        output in_valid, in_instr, flush,
        input  in_ready, fpu_instr, fpu_valid, illegal, hazard_stall
    );

    modport slave (
        input  in_valid, in_instr, flush,
        output in_ready, fpu_instr, fpu_valid, illegal, hazard_stall
    );
endinterface

// File: rtl/fpu_issue_fifo.sv
// Circular-buffer FIFO with wrapping pointers and an occupancy count.
//   clk, rst_n : clock, synchronous active-low reset
//   push/wdata : write (ignored when full or during flush)
//   pop/rdata  : read head (rdata is the current head, ignored when empty)
//   flush      : empty the FIFO, overriding any same-cycle push/pop
//   full/empty : occupancy flags
module fpu_issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        rdata   = mem[rd_ptr];
        do_push = push & ~full & ~flush;
        do_pop  = pop & ~empty & ~flush;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fpu_issue.sv
// In-order issue stage in front of the fixed-latency FPU pipeline.
// Queues instructions, decodes source usage, tracks in-flight destinations
// with per-register countdowns and holds the head on a RAW hazard.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fpu_issue_if slave (upstream push, flush, FPU issue, status)
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned WB_LATENCY   = 4,
    parameter logic [31:0] BUBBLE_INSTR = BUBBLE
) (
    input  logic        clk,
    input  logic        rst_n,
    fpu_issue_if.slave  bus
);
    localparam int unsigned CNTW = $clog2(WB_LATENCY + 1);

    logic [31:0]     head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic [CNTW-1:0] cnt [32];
    src_use_t        use_h;
    logic [4:0]      rs1, rs2, rs3, rd;
    logic            hazard;
    issue_act_e      act;

    logic [31:0]     instr_q;
    logic            valid_q;
    logic            illegal_q;
    logic            stall_q;

    fpu_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .pop   (pop),
        .flush (bus.flush),
        .wdata (bus.in_instr),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        use_h  = fp_src_use(head);
        rs1    = head[19:15];
        rs2    = head[24:20];
        rs3    = head[31:27];
        rd     = head[11:7];
        // Fixed latency and in-order issue make RAW the only hazard.
        hazard = (cnt[rs1] != '0)
               | (use_h.use_rs2 & (cnt[rs2] != '0))
               | (use_h.use_rs3 & (cnt[rs3] != '0));

        act = ACT_ISSUE;
        if (bus.flush)         act = ACT_FLUSH;
        else if (fifo_empty)   act = ACT_IDLE;
        else if (!use_h.legal) act = ACT_ILLEGAL;
        else if (hazard)       act = ACT_STALL;

        pop = (act == ACT_ILLEGAL) | (act == ACT_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q   <= BUBBLE_INSTR;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            instr_q   <= (act == ACT_ISSUE) ? head : BUBBLE_INSTR;
            valid_q   <= (act == ACT_ISSUE);
            illegal_q <= (act == ACT_ILLEGAL);
            stall_q   <= (act == ACT_STALL);
        end
    end

    // A load on issue wins over the decrement of the same register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (act == ACT_ISSUE && rd == 5'(i))
                    cnt[i] <= CNTW'(WB_LATENCY);
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - CNTW'(1);
            end
        end
    end

    assign bus.in_ready     = ~fifo_full;
    assign bus.fpu_instr    = instr_q;
    assign bus.fpu_valid    = valid_q;
    assign bus.illegal      = illegal_q;
    assign bus.hazard_stall = stall_q;

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- In-order issue stage that feeds the 4-stage FPU pipeline. The FPU has no forwarding, no hazard logic and no handshake.
- Buffers incoming FP instructions in a small FIFO, decodes source/destination usage, tracks in-flight destinations with a per-register countdown scoreboard, and holds any instruction with a RAW hazard.
- Emits exactly one registered instruction (or bubble) per cycle, qualified by fpu_valid. The FPU gates its writeback with fpu_valid.

Parameters:
- DEPTH, 4, input FIFO entries (power of 2, ≥2).
- WB_LATENCY, 4, number of clk edges from the issue edge to the FPU regfile write edge.
- BUBBLE_INSTR, 32'h00000000, value driven on fpu_instr when fpu_valid=0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_instr  in  32  upstream RISC-V F-extension instruction.
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid & in_ready.
- flush  in  1  discard all queued (unissued) instructions.
- fpu_instr  out  32  registered instruction to FPU.
- fpu_valid  out  1  registered; fpu_instr is a real instruction.
- illegal  out  1  registered one-cycle pulse when the head instruction is dropped as unsupported.
- hazard_stall  out  1  registered; 1 when the head was held for a RAW hazard in the previous cycle.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FIFO empty; all 32 scoreboard counters 0.
  - fpu_valid=0, fpu_instr=BUBBLE_INSTR, illegal=0, hazard_stall=0.
  - Reset mid-stream drops queued and in-flight tracking.
- in_ready = !full. It is combinational from FIFO state only and does not depend on a same-cycle pop. Push when full is impossible by construction.
- Head decode uses opcode[6:2] and funct5=[31:27]:
  - 100xx (FMADD/FMSUB/FNMSUB/FNMADD): uses rs1, rs2, rs3; writes rd.
  - 10100, funct5 ∈ {00000, 00001, 00010, 00011, 00100, 00101, 10100}: uses rs1, rs2; writes rd.
  - 10100, funct5 = 01011 (FSQRT): uses rs1 only.
  - 10100, funct5 = 11100 with funct3[0]=1 (FCLASS): uses rs1 only.
  - All other encodings are illegal. This includes the FCVT/FMV funct5 values 11000, 11010, 11110 and 11100 with funct3[0]=0.
- Hazard: hazard = (cnt[rs1]≠0) | (uses_rs2 & cnt[rs2]≠0) | (uses_rs3 & cnt[rs3]≠0). No WAW or WAR stall is needed, because latency is fixed and issue is in order.
- Each edge, evaluated on the head in priority order:
  - (a) flush=1: FIFO emptied (any same-cycle push is also discarded), fpu_valid←0, illegal←0; scoreboard keeps counting.
  - (b) FIFO empty: fpu_valid←0, fpu_instr←BUBBLE_INSTR.
  - (c) head illegal: pop, fpu_valid←0, illegal←1.
  - (d) head hazard: no pop, fpu_valid←0, hazard_stall←1.
  - (e) otherwise issue: pop, fpu_instr←head, fpu_valid←1, cnt[rd]←WB_LATENCY.
- Scoreboard:
  - Each nonzero counter decrements by 1 per edge.
  - A load on issue takes priority over the decrement of that same register.
  - Counter width is $clog2(WB_LATENCY+1).
- Timing:
  - Empty FIFO, push at edge E: earliest issue at edge E+1 (fpu_valid high after E+1).
  - Dependent instruction: earliest issue edge = producer issue edge + WB_LATENCY + 1.
  - Independent back-to-back instructions issue on consecutive edges (full throughput).
- FIFO: circular buffer with wrapping read/write pointers plus a count. Simultaneous push and pop keeps the count unchanged.
- f0 is an ordinary FP register; it is tracked like any other register.

Decomposition:
- fpu_pkg (shared) holds:
  - opcode constants OPC_FP_R4 = 5'b100xx group and OPC_OP_FP = 5'b10100;
  - funct5 constants for each op;
  - BUBBLE default;
  - a function fp_src_use(instr) returning {legal, use_rs2, use_rs3}, which can be reused by the decode stage.
- One sub-module, fpu_issue_fifo (DEPTH, WIDTH=32; push/pop/flush/full/empty). The scoreboard and issue logic stay in fpu_issue.

Test Plan:
- Reset, then push FADD f3,f1,f2 (0x002081D3):
  - fpu_valid=1 and fpu_instr=0x002081D3 exactly one edge after acceptance;
  - illegal=0, hazard_stall=0.
- Push 0x002081D3 then FMUL f4,f3,f3 (0x10318253) back-to-back:
  - FMUL issues exactly WB_LATENCY+1=5 edges after FADD;
  - hazard_stall=1 for the intervening cycles; bubbles show fpu_valid=0.
- Push 0x002081D3 then an independent FADD f5,f6,f7 (0x007302D3): both issue on consecutive edges with no stall.
- Push FMV.X.W 0xE0000053 followed by 0x002081D3:
  - illegal pulses for one cycle, with no fpu_valid for it;
  - the FADD issues on the next edge.
- Fill the FIFO with DEPTH dependent instructions while in_valid stays high:
  - in_ready=0 at count=DEPTH and extra words are not accepted;
  - after drain, pointer wrap preserves order.
- Assert flush while 3 entries are queued, with FADD f3 in flight:
  - queue empties and fpu_valid=0 on the next cycle;
  - a new FMUL reading f3 still stalls until cnt[f3] reaches 0.
- Assert rst_n=0 mid-stall: all outputs return to their reset values on that edge.
